// File: rtl/game_pkg.sv
// Shared definitions for the player-path game logic: state encodings,
// sword sprite codes and tile-grid geometry.
package game_pkg;

  localparam int POS_W     = 8;
  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 12;

  localparam logic [3:0] SWORD_ACTIVE = 4'b0001;
  localparam logic [3:0] SWORD_HIDDEN = 4'b1111;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HIT       = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

endpackage

// File: rtl/collision_detect.sv
// Tile-equality compare of the player and the drawn sword against one enemy.
module collision_detect
  import game_pkg::*;
#(
  parameter logic [3:0] SWORD_CODE = 4'b0001
) (
  input  logic [POS_W-1:0] player_pos,
  input  logic [POS_W-1:0] sword_position,
  input  logic [3:0]       sword_visible,
  input  logic [POS_W-1:0] enemy_pos,
  input  logic             enemy_valid,
  output logic             player_col,
  output logic             sword_col
);

  assign player_col = enemy_valid && (player_pos == enemy_pos);
  assign sword_col  = enemy_valid && (sword_visible == SWORD_CODE) &&
                      (sword_position == enemy_pos);

endmodule

// File: rtl/game_state_controller.sv
// Frame-driven lives / hit / respawn / invulnerability / game-over sequencer
// with registered outputs and per-enemy sword kill pulses.
module game_state_controller
  import game_pkg::*;
#(
  parameter int         N_ENEMY        = 4,
  parameter int         LIVES_INIT     = 3,
  parameter int         RESPAWN_FRAMES = 16,
  parameter int         INVULN_FRAMES  = 40,
  parameter logic [3:0] SWORD_ACTIVE   = 4'b0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic                 restart,
  input  logic [7:0]           player_pos,
  input  logic [7:0]           sword_position,
  input  logic [3:0]           sword_visible,
  input  logic [8*N_ENEMY-1:0] enemy_pos,
  input  logic [N_ENEMY-1:0]   enemy_valid,
  output logic [1:0]           game_state,
  output logic [1:0]           lives,
  output logic                 player_respawn,
  output logic                 player_blink,
  output logic [N_ENEMY-1:0]   enemy_hit,
  output logic                 game_over
);

  localparam logic [5:0] RESPAWN_LAST = 6'(RESPAWN_FRAMES - 1);
  localparam logic [5:0] INVULN_LAST  = 6'(INVULN_FRAMES - 1);
  localparam logic [1:0] LIVES_RELOAD = 2'(LIVES_INIT);

  game_state_t          state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [5:0]           cnt_q, cnt_d, cnt_inc;
  logic                 blink_q, blink_d;
  logic                 respawn_q, respawn_d;
  logic                 game_over_q;
  logic                 boot_q;
  logic [N_ENEMY-1:0]   hit_q, hit_d;
  logic [N_ENEMY-1:0]   player_col, sword_col;
  logic                 body_hit;

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_col
    collision_detect #(.SWORD_CODE(SWORD_ACTIVE)) u_col (
      .player_pos    (player_pos),
      .sword_position(sword_position),
      .sword_visible (sword_visible),
      .enemy_pos     (enemy_pos[8*i +: 8]),
      .enemy_valid   (enemy_valid[i]),
      .player_col    (player_col[i]),
      .sword_col     (sword_col[i])
    );
  end

  // A body contact on a tile the sword is also killing does not count.
  assign body_hit = |(player_col & ~sword_col);
  assign cnt_inc  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    blink_d   = blink_q;
    hit_d     = '0;
    respawn_d = 1'b0;
    if (trigger) begin
      case (state_q)
        PLAY: begin
          hit_d = sword_col;
          if (body_hit) begin
            if (lives_q <= 2'd1) begin
              state_d = GAME_OVER;
              lives_d = 2'd0;
            end else begin
              state_d = HIT;
              lives_d = lives_q - 2'd1;
              cnt_d   = 6'd0;
            end
          end
        end
        HIT: begin
          hit_d = sword_col;
          if (cnt_q == RESPAWN_LAST) begin
            state_d   = INVULN;
            respawn_d = 1'b1;
            cnt_d     = 6'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        INVULN: begin
          hit_d = sword_col;
          if (cnt_q == INVULN_LAST) begin
            state_d = PLAY;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        GAME_OVER: begin
          if (restart) begin
            state_d   = INVULN;
            lives_d   = LIVES_RELOAD;
            respawn_d = 1'b1;
            cnt_d     = 6'd0;
          end
        end
        default: ;
      endcase
      blink_d = (state_d == INVULN) && cnt_d[2];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      lives_q     <= LIVES_RELOAD;
      cnt_q       <= 6'd0;
      blink_q     <= 1'b0;
      hit_q       <= '0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      boot_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      hit_q       <= hit_d;
      // The first edge out of reset re-initialises the player logic.
      respawn_q   <= respawn_d | boot_q;
      game_over_q <= (state_d == GAME_OVER);
      boot_q      <= 1'b0;
    end
  end

  assign game_state     = state_q;
  assign lives          = lives_q;
  assign player_respawn = respawn_q;
  assign player_blink   = blink_q;
  assign enemy_hit      = hit_q;
  assign game_over      = game_over_q;

endmodule
